// File: rtl/wide_add_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer_pkg
// Description : Shared state encoding and chunk width for the wide adder
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package wide_add_sequencer_pkg;

    // Width of one slice handled by the shared external adder
    localparam int CHUNK = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : wide_add_sequencer_pkg
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer
// Description : Performs a WORDS x 8-bit add/subtract by time-multiplexing one
//               slow external 8-bit adder, LSB chunk first. Operands are held
//               for SETTLE+1 cycles before each chunk result is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORDS  = 4,
    parameter int SETTLE = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic [CHUNK*WORDS-1:0]   a,
    input  logic [CHUNK*WORDS-1:0]   b,
    input  logic                     cin,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [CHUNK*WORDS-1:0]   sum,
    output logic                     cout,
    output logic [CHUNK-1:0]         add_a,
    output logic [CHUNK-1:0]         add_b,
    output logic                     add_cin,
    input  logic [CHUNK-1:0]         add_s,
    input  logic                     add_co
);

    localparam int IDXW = (WORDS > 1)  ? $clog2(WORDS)      : 1;
    localparam int CNTW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(WORDS - 1);
    localparam logic [CNTW-1:0] c_SETTLE   = CNTW'(SETTLE);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_last;
    logic [IDXW-1:0]          w_next_idx;
    logic [CHUNK*WORDS-1:0]   w_b_in;

    logic [CHUNK*WORDS-1:0]   r_a;
    logic [CHUNK*WORDS-1:0]   r_b;
    logic                     r_carry;
    logic [IDXW-1:0]          r_idx;
    logic [CNTW-1:0]          r_cnt;

    // Subtraction is a + ~b + 1, so B is stored pre-inverted
    assign w_b_in     = sub ? ~b : b;
    assign w_capture  = (r_state == ST_RUN) && (r_cnt == c_SETTLE);
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_next_idx = r_idx + IDXW'(1);

    // The inter-chunk carry register is what drives the adder carry-in
    assign add_cin    = r_carry;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_capture && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch, settle counter, chunk sequencing and result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            add_a   <= '0;
            add_b   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_cnt   <= '0;
            sum     <= '0;
            add_a   <= a[CHUNK-1:0];
            add_b   <= w_b_in[CHUNK-1:0];
        end else if (r_state == ST_RUN) begin
            if (!w_capture) begin
                r_cnt <= r_cnt + CNTW'(1);
            end else begin
                sum[CHUNK*r_idx +: CHUNK] <= add_s;
                r_carry                   <= add_co;
                r_cnt                     <= '0;
                if (!w_last) begin
                    r_idx <= w_next_idx;
                    add_a <= r_a[CHUNK*w_next_idx +: CHUNK];
                    add_b <= r_b[CHUNK*w_next_idx +: CHUNK];
                end else begin
                    cout  <= add_co;
                end
            end
        end
    end

endmodule : wide_add_sequencer
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_sequencer
// Description : Self-checking bench for wide_add_sequencer with a slow,
//               glitching 8-bit adder model on the add_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

    localparam int WORDS   = 4;
    localparam int SETTLE  = 15;
    localparam int W       = 8 * WORDS;
    localparam int LATENCY = WORDS * (SETTLE + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          ready, busy, done, cout, add_cin, add_co;
    logic [W-1:0]  sum;
    logic [7:0]    add_a, add_b, add_s;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int op_e0      = 0;
    int done_cnt   = 0;
    int ops_done   = 0;
    bit mon_en     = 1'b0;
    logic [16:0] mon_prev = '0;

    wide_add_sequencer #(.WORDS(WORDS), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .ready(ready), .busy(busy), .done(done), .sum(sum),
        .cout(cout), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_co(add_co)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on every rising edge
    always @(posedge clk) cyc++;

    // Slow adder: garbage right after an operand change, correct after 130 ns
    initial {add_co, add_s} = 9'd0;
    always @(add_a or add_b or add_cin) begin
        {add_co, add_s} = 9'($urandom);
        #130;
        {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Adder operands may only move on accept/capture edges
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mon_en && ({add_a, add_b, add_cin} !== mon_prev)) begin
            chk("operand change on capture edge",
                64'((cyc - op_e0) % (SETTLE + 1)), 64'd0);
        end
        mon_prev = {add_a, add_b, add_cin};
    end

    // Reference: plain wide arithmetic
    function automatic logic [W:0] model(input logic s_sub, input logic [W-1:0] s_a,
                                         input logic [W-1:0] s_b, input logic s_cin);
        logic [W:0] r;
        if (s_sub) begin
            r[W-1:0] = s_a - s_b;
            r[W]     = (s_a >= s_b);
        end else begin
            r = {1'b0, s_a} + {1'b0, s_b} + (W+1)'(s_cin);
        end
        return r;
    endfunction

    task automatic do_op(input string tag, input logic s_sub, input logic [W-1:0] s_a,
                         input logic [W-1:0] s_b, input logic s_cin, input bit poke);
        logic [W:0] exp;
        int         n;
        bit         got;
        exp = model(s_sub, s_a, s_b, s_cin);
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready before start"}, 64'(ready), 64'd1);
        sub   = s_sub;
        a     = s_a;
        b     = s_b;
        cin   = s_cin;
        start = 1'b1;
        op_e0 = cyc + 1;
        got   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && ((cyc - op_e0) == 5 || (cyc - op_e0) == 30)) begin
                chk({tag, " ready low while running"}, 64'(ready), 64'd0);
                sub   = ~sub;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = ~cin;
                start = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " done seen"}, 64'(got), 64'd1);
        if (got) begin
            ops_done++;
            chk({tag, " latency"}, 64'(cyc - op_e0), 64'(LATENCY));
            chk({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
            chk({tag, " cout"}, 64'(cout), 64'(exp[W]));
            chk({tag, " busy in done"}, 64'({busy, ready}), 64'b10);
            @(negedge clk);
            chk({tag, " done one cycle"}, 64'({done, ready, busy}), 64'b010);
            repeat (3) @(negedge clk);
            chk({tag, " sum held"}, 64'({cout, sum}), 64'(exp));
        end
    endtask

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [W:0] r;
        int         n;
        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        tbl[1] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1};
        tbl[4] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tbl[6] = '{1'b0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset status", 64'({ready, busy, done}), 64'b100);
        chk("reset outputs", 64'({sum, cout, add_a, add_b, add_cin}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Directed vectors, also confirming the model agrees with the table
        for (int i = 0; i < 7; i++) begin
            r = model(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin);
            chk($sformatf("table %0d model", i), 64'(r), 64'({tbl[i].co, tbl[i].s}));
            do_op($sformatf("vec%0d", i), tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
        end

        // Starts during RUN are ignored
        do_op("ignored starts", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);

        // Asynchronous reset during chunk 2
        @(negedge clk);
        sub = 1'b0; a = 32'h89AB_CDEF; b = 32'h7654_3210; cin = 1'b1;
        start = 1'b1;
        op_e0 = cyc + 1;
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while ((cyc - op_e0) < 40 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached chunk 2", 64'(busy), 64'd1);
        n = done_cnt;
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async reset status", 64'({ready, busy, done}), 64'b100);
        chk("async reset sum", 64'(sum), 64'd0);
        chk("async reset adder ports", 64'({cout, add_a, add_b, add_cin}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("no done after abort", 64'(done_cnt), 64'(n));
        mon_en = 1'b1;
        do_op("after reset", 1'b0, 32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("rand%0d", i), 1'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), 1'b0);
        end

        chk("done pulse count", 64'(done_cnt), 64'(ops_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_wide_add_sequencer
`default_nettype wire
